// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers (EX stage).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; clears HI/LO, pending result and counter
//   start      one-cycle request, ignored while busy
//   XALUOp     000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 msub, 111 reserved
//   A, B       rs / rt operands, sampled on the accepting edge
//   hilo_ctrl  read select for out: 0 = HI, 1 = LO
//   out        combinational read of the committed HI/LO
//   busy       high while a multiply or divide result is pending
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  XALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hilo_ctrl,
  output logic [31:0] out,
  output logic        busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MSUB  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  op_e              op;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [CNT_W-1:0] cnt;

  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] msub_res;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign op = op_e'(XALUOp);

  // Low 64 bits of the product of sign-extended operands give the exact signed product.
  always_comb begin
    a_sx     = {{32{A[31]}}, A};
    b_sx     = {{32{B[31]}}, B};
    prod_s   = a_sx * b_sx;
    prod_u   = {32'd0, A} * {32'd0, B};
    msub_res = {hi, lo} - prod_s;
  end

  // Signed divide runs on magnitudes through the shared unsigned divider. The
  // 0x80000000 / -1 case falls out naturally: magnitude 0x80000000, no sign flip.
  always_comb begin
    a_neg = (op == OP_DIV) && A[31];
    b_neg = (op == OP_DIV) && B[31];
    a_mag = a_neg ? (32'd0 - A) : A;
    b_mag = b_neg ? (32'd0 - B) : B;
    b_div = (B == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          {pend_hi, pend_lo} <= prod_s;
          cnt                <= CNT_MULT;
        end
        OP_MULTU: begin
          {pend_hi, pend_lo} <= prod_u;
          cnt                <= CNT_MULT;
        end
        OP_MSUB: begin
          {pend_hi, pend_lo} <= msub_res;
          cnt                <= CNT_MULT;
        end
        OP_DIV, OP_DIVU: begin
          // Divide by zero recommits the current HI/LO after the normal latency.
          if (B == 32'd0) begin
            pend_hi <= hi;
            pend_lo <= lo;
          end else begin
            pend_hi <= rem;
            pend_lo <= quot;
          end
          cnt <= CNT_DIV;
        end
        OP_MTHI: hi <= A;
        OP_MTLO: lo <= A;
        OP_RSVD: ;
      endcase
    end
  end

  assign out  = hilo_ctrl ? lo : hi;
  assign busy = (cnt != '0);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. The stimulus process pushes the
// expected HI/LO (and busy length) for every accepted operation; the monitor
// pops on each commit (busy falling), each mthi/mtlo, and each probe request.
module tb_md_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  XALUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        hilo_ctrl;
  logic [31:0] out;
  logic        busy;
  logic        probe;

  // cycles: -1 = probe of idle state, 0 = mthi/mtlo, N = busy length before commit
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .XALUOp   (XALUOp),
    .A        (A),
    .B        (B),
    .hilo_ctrl(hilo_ctrl),
    .out      (out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitor ----------------
  int   run;
  logic prev_busy;
  logic acc_mt;

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    hilo_ctrl = 1'b0;
    #1 h = out;
    hilo_ctrl = 1'b1;
    #1 l = out;
    hilo_ctrl = 1'b0;
  endtask

  task automatic consume(input int run_len, input string tag);
    exp_t        e;
    logic [31:0] h;
    logic [31:0] l;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_unexpected: got output event expected none at %0t", tag, $time);
    end else begin
      e = q.pop_front();
      check32({tag, "_cycles"}, 32'(run_len), 32'(e.cycles));
      read_hilo(h, l);
      check32({tag, "_hi"}, h, e.hi);
      check32({tag, "_lo"}, l, e.lo);
    end
  endtask

  initial begin
    exp_t        e;
    logic [31:0] h;
    logic [31:0] l;
    hilo_ctrl = 1'b0;
    run       = 0;
    prev_busy = 1'b0;
    acc_mt    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run       = 0;
        prev_busy = 1'b0;
        acc_mt    = 1'b0;
      end else begin
        if (acc_mt) consume(0, "mt");
        if (prev_busy && !busy) consume(run, "commit");
        if (busy) run++;
        else      run = 0;
        prev_busy = busy;
      end
      if (probe) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL probe_empty: got no entry expected probe entry at %0t", $time);
        end else begin
          e = q.pop_front();
          check32("probe_kind", 32'(e.cycles), 32'hFFFF_FFFF);
          check32("probe_busy", {31'd0, busy}, 32'd0);
          read_hilo(h, l);
          check32("probe_hi", h, e.hi);
          check32("probe_lo", l, e.lo);
        end
      end
      acc_mt = start && !busy && !reset && (XALUOp == OP_MTHI || XALUOp == OP_MTLO);
    end
  end

  // ---------------- stimulus ----------------
  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    XALUOp = op;
    A      = a;
    B      = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (busy) check32("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    q.push_back('{hi: ehi, lo: elo, cycles: cyc});
    pulse(op, a, b);
    wait_idle();
  endtask

  task automatic do_probe(input logic [31:0] ehi, input logic [31:0] elo);
    q.push_back('{hi: ehi, lo: elo, cycles: -1});
    probe = 1'b1;
    @(posedge clk);
    #1 probe = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    probe  = 1'b0;
    XALUOp = 3'b000;
    A      = '0;
    B      = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_probe(32'h0, 32'h0);

    // reset in the middle of a multiply discards it
    pulse(OP_MULT, 32'd3, 32'd4);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check32("reset_busy_async", {31'd0, busy}, 32'd0);
    do_probe(32'h0, 32'h0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 do_probe(32'h0, 32'h0);

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op(OP_MTLO,  32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 0);
    run_op(OP_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 10);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    run_op(OP_MTHI,  32'd0,         32'd0,         32'h0000_0000, 32'h8000_0000, 0);
    run_op(OP_MTLO,  32'd10,        32'd0,         32'h0000_0000, 32'h0000_000A, 0);

    // msub with a mult attempted while it is in flight; the mult must be dropped
    q.push_back('{hi: 32'h0, lo: 32'h4, cycles: 5});
    pulse(OP_MSUB, 32'd2, 32'd3);
    pulse(OP_MULT, 32'd5, 32'd5);
    wait_idle();

    // msub borrowing across the HI/LO boundary: 4 - 15 = -11
    run_op(OP_MSUB,  32'd3,         32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF5, 5);
    run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999, 10);
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);

    // reserved opcode leaves everything untouched
    pulse(OP_RSVD, 32'hDEAD_BEEF, 32'h1);
    do_probe(32'h0000_0001, 32'hFFFF_FFFD);

    repeat (3) @(posedge clk);
    #1 check32("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
